fwd_operand_pipe: RTL and testbench

- Parametrised successor to the fixed 3:1 forwarding select.
- Resolves one source operand against NSTAGE producer stages plus the register file.
- Priority-picks the youngest matching producer and detects load-use hazards.
- Delivers the operand through a registered, stall/flush-aware output stage.
- Instantiated once per operand (rs1, rs2) between ID/EX decode and the ALU input.

---
 rtl/fwd_operand_pipe.sv | 121 ++++++++++++
 tb/tb_fwd_operand_pipe.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fwd_operand_pipe.sv
// fwd_operand_pipe: resolves one source operand against NSTAGE producer
// stages and the register file. The youngest matching producer wins, and a
// pending winner raises HAZARD. The operand is delivered through a
// registered output stage that is aware of stall and flush.
// Optional build macro: FWD_OPERAND_STATS_EN enables the forwarded-operand
// counter on FWD_COUNT. Without it, FWD_COUNT is tied to zero.
module fwd_operand_pipe #(
    parameter int XLEN   = 32,
    parameter int REGW   = 5,
    parameter int NSTAGE = 2,
    parameter int SELW   = $clog2(NSTAGE + 1)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     STALL,
    input  logic                     FLUSH,
    input  logic                     IN_VALID,
    input  logic [REGW-1:0]          RS_ADDR,
    input  logic [XLEN-1:0]          RF_DATA,
    input  logic [NSTAGE-1:0]        FWD_WE,
    input  logic [NSTAGE-1:0]        FWD_PEND,
    input  logic [NSTAGE*REGW-1:0]   FWD_RD,
    input  logic [NSTAGE*XLEN-1:0]   FWD_DATA,
    output logic                     HAZARD,
    output logic                     OUT_VALID,
    output logic [XLEN-1:0]          OUT_DATA,
    output logic [SELW-1:0]          OUT_SEL,
    output logic [31:0]              FWD_COUNT
);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_found;
    logic              w_win_pend;
    logic [XLEN-1:0]   w_data;
    logic [SELW-1:0]   w_sel;
    logic              w_capture;

    // Priority pick: the first (youngest) matching stage wins; x0 never forwards
    always_comb begin
        w_found    = 1'b0;
        w_win_pend = 1'b0;
        w_data     = RF_DATA;
        w_sel      = '0;
        for (int unsigned k = 0; k < NSTAGE; k++) begin
            if (!w_found && FWD_WE[k] &&
                (FWD_RD[k*REGW +: REGW] == RS_ADDR) && (RS_ADDR != '0)) begin
                w_found    = 1'b1;
                w_win_pend = FWD_PEND[k];
                w_data     = FWD_DATA[k*XLEN +: XLEN];
                w_sel      = SELW'(k + 1);
            end
        end
    end

    assign HAZARD    = IN_VALID && w_found && w_win_pend;
    assign w_capture = IN_VALID && !HAZARD;

    // Next-state logic: flush forces IDLE, stall holds, otherwise follow HAZARD
    always_comb begin
        w_state_nxt = r_state;
        if (FLUSH) begin
            w_state_nxt = ST_IDLE;
        end else if (!STALL) begin
            case (r_state)
                ST_IDLE: if (IN_VALID && HAZARD) w_state_nxt = ST_WAIT;
                ST_WAIT: if (!HAZARD)            w_state_nxt = ST_IDLE;
                default:                         w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Output stage: flush clears, stall holds, otherwise capture the select result
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OUT_VALID <= 1'b0;
            OUT_DATA  <= '0;
            OUT_SEL   <= '0;
        end else if (FLUSH) begin
            OUT_VALID <= 1'b0;
            OUT_DATA  <= '0;
            OUT_SEL   <= '0;
        end else if (!STALL) begin
            OUT_VALID <= w_capture;
            if (w_capture) begin
                OUT_DATA <= w_data;
                OUT_SEL  <= w_sel;
            end
        end
    end

`ifdef FWD_OPERAND_STATS_EN
    logic [31:0] r_fwd_count;

    // Saturating count of captured operands taken from a producer stage
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_fwd_count <= '0;
        end else if (!FLUSH && !STALL && w_capture && (w_sel != '0) &&
                     (r_fwd_count != '1)) begin
            r_fwd_count <= r_fwd_count + 32'd1;
        end
    end

    assign FWD_COUNT = r_fwd_count;
`else
    assign FWD_COUNT = '0;
`endif

endmodule

// File: tb/tb_fwd_operand_pipe.sv
// Self-checking bench for fwd_operand_pipe (NSTAGE=2, XLEN=32, REGW=5).
// Vectors carry hand-derived expectations. Each applied vector pushes its
// expected registered result to a queue, which is popped and compared after
// the next rising edge.
module tb_fwd_operand_pipe;

    logic        CLK = 1'b0;
    logic        RST;
    logic        STALL, FLUSH, IN_VALID;
    logic [4:0]  RS_ADDR;
    logic [31:0] RF_DATA;
    logic [1:0]  FWD_WE, FWD_PEND;
    logic [9:0]  FWD_RD;
    logic [63:0] FWD_DATA;
    logic        HAZARD, OUT_VALID;
    logic [31:0] OUT_DATA;
    logic [1:0]  OUT_SEL;
    logic [31:0] FWD_COUNT;

    fwd_operand_pipe #(.XLEN(32), .REGW(5), .NSTAGE(2)) dut (
        .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .RS_ADDR(RS_ADDR), .RF_DATA(RF_DATA),
        .FWD_WE(FWD_WE), .FWD_PEND(FWD_PEND), .FWD_RD(FWD_RD),
        .FWD_DATA(FWD_DATA), .HAZARD(HAZARD), .OUT_VALID(OUT_VALID),
        .OUT_DATA(OUT_DATA), .OUT_SEL(OUT_SEL), .FWD_COUNT(FWD_COUNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        stall, flush, v;
        logic [4:0]  rs;
        logic [31:0] rf;
        logic [1:0]  we, pend;
        logic [4:0]  rd0, rd1;
        logic [31:0] d0, d1;
        logic        haz;   // expected HAZARD
        logic        ev;    // expected OUT_VALID loaded when unstalled/unflushed
        logic [31:0] ed;    // expected OUT_DATA when ev=1
        logic [1:0]  es;    // expected OUT_SEL when ev=1
    } vec_t;

    typedef struct {
        logic        valid;
        logic [31:0] data;
        logic [1:0]  sel;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        held;
    int          n_pass = 0;
    int          n_total = 0;
    vec_t        tbl[9];
    vec_t        t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        else n_pass++;
    endtask

    task automatic apply(input vec_t x, input string name);
        exp_t e;
        @(negedge CLK);
        STALL = x.stall; FLUSH = x.flush; IN_VALID = x.v;
        RS_ADDR = x.rs; RF_DATA = x.rf; FWD_WE = x.we; FWD_PEND = x.pend;
        FWD_RD = {x.rd1, x.rd0}; FWD_DATA = {x.d1, x.d0};
        #1;
        chk({name, ".hazard"}, 32'(HAZARD), 32'(x.haz));
        if (x.flush) begin
            e = '{1'b0, 32'h0, 2'd0};
        end else if (x.stall) begin
            e = held;
        end else begin
            e = held;
            e.valid = x.ev;
            if (x.ev) begin
                e.data = x.ed;
                e.sel  = x.es;
            end
        end
        held = e;
        sb_q.push_back(e);
        @(posedge CLK);
        #1;
        e = sb_q.pop_front();
        chk({name, ".valid"}, 32'(OUT_VALID), 32'(e.valid));
        chk({name, ".data"},  OUT_DATA,       e.data);
        chk({name, ".sel"},   32'(OUT_SEL),   32'(e.sel));
    endtask

    task automatic pulse_reset(input string name);
        @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        chk({name, ".valid"}, 32'(OUT_VALID), 32'd0);
        chk({name, ".data"},  OUT_DATA,       32'd0);
        chk({name, ".sel"},   32'(OUT_SEL),   32'd0);
        chk({name, ".count"}, FWD_COUNT,      32'd0);
        #1 RST = 1'b0;
        held = '{1'b0, 32'h0, 2'd0};
    endtask

    initial begin
        //         st   fl   v    rs  rf      we     pend   rd0 rd1 d0      d1      haz  ev   ed      es
        tbl[0] = '{1'b0,1'b0,1'b1,5'd5, 32'h11,2'b11,2'b00,5'd5,5'd5,32'hAA,32'hBB,1'b0,1'b1,32'hAA,2'd1};
        tbl[1] = '{1'b0,1'b0,1'b1,5'd5, 32'h11,2'b10,2'b00,5'd5,5'd5,32'hAA,32'hBB,1'b0,1'b1,32'hBB,2'd2};
        tbl[2] = '{1'b0,1'b0,1'b1,5'd0, 32'h33,2'b11,2'b11,5'd0,5'd0,32'hAA,32'hBB,1'b0,1'b1,32'h33,2'd0};
        tbl[3] = '{1'b0,1'b0,1'b1,5'd3, 32'h44,2'b11,2'b00,5'd5,5'd5,32'hAA,32'hBB,1'b0,1'b1,32'h44,2'd0};
        tbl[4] = '{1'b0,1'b0,1'b1,5'd9, 32'h55,2'b11,2'b01,5'd9,5'd9,32'hC0,32'hC1,1'b1,1'b0,32'h0, 2'd0};
        tbl[5] = '{1'b0,1'b0,1'b1,5'd9, 32'h55,2'b11,2'b10,5'd9,5'd9,32'hC0,32'hC1,1'b0,1'b1,32'hC0,2'd1};
        tbl[6] = '{1'b0,1'b0,1'b0,5'd9, 32'h55,2'b11,2'b01,5'd9,5'd9,32'hC2,32'hC3,1'b0,1'b0,32'h0, 2'd0};
        tbl[7] = '{1'b0,1'b0,1'b1,5'd12,32'h66,2'b10,2'b01,5'd12,5'd12,32'hD0,32'hD1,1'b0,1'b1,32'hD1,2'd2};
        tbl[8] = '{1'b0,1'b0,1'b1,5'd12,32'h77,2'b00,2'b00,5'd12,5'd12,32'hD0,32'hD1,1'b0,1'b1,32'h77,2'd0};

        RST = 1'b1; STALL = 1'b0; FLUSH = 1'b0; IN_VALID = 1'b0;
        RS_ADDR = '0; RF_DATA = '0; FWD_WE = '0; FWD_PEND = '0; FWD_RD = '0; FWD_DATA = '0;
        held = '{1'b0, 32'h0, 2'd0};
        #12;
        chk("reset.valid", 32'(OUT_VALID), 32'd0);
        chk("reset.data",  OUT_DATA,       32'd0);
        chk("reset.sel",   32'(OUT_SEL),   32'd0);
        chk("reset.count", FWD_COUNT,      32'd0);
        RST = 1'b0;

        for (int i = 0; i < 9; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // load-use: two blocked cycles, then the producer completes
        t = '{1'b0,1'b0,1'b1,5'd7,32'h99,2'b01,2'b01,5'd7,5'd0,32'h0,32'h0,1'b1,1'b0,32'h0,2'd0};
        apply(t, "wait0");
        apply(t, "wait1");
        t.pend = 2'b00; t.d0 = 32'h42; t.haz = 1'b0; t.ev = 1'b1; t.ed = 32'h42; t.es = 2'd1;
        apply(t, "release");

        // capture, then stall three cycles with changing inputs
        apply(tbl[0], "pre_stall");
        for (int i = 0; i < 3; i++) begin
            t = tbl[3 + i];
            t.stall = 1'b1;
            t.rf = 32'h100 + 32'(i);
            apply(t, $sformatf("stall%0d", i));
        end
        // flush with stall and a live hazard: registers clear, HAZARD still follows inputs
        t = tbl[4];
        t.stall = 1'b1; t.flush = 1'b1;
        apply(t, "flush_stall");
        apply(tbl[1], "post_flush");

        // reset while blocked on a pending producer
        apply(tbl[4], "pre_rst_wait");
        pulse_reset("rst_mid_wait");
        apply(tbl[3], "post_rst");

        // counter: 4 forwarded + 2 register-file operands after a clean reset
        pulse_reset("rst_count");
        apply(tbl[0], "cnt_f0");
        apply(tbl[1], "cnt_f1");
        apply(tbl[3], "cnt_r0");
        apply(tbl[5], "cnt_f2");
        apply(tbl[8], "cnt_r1");
        apply(tbl[7], "cnt_f3");
`ifdef FWD_OPERAND_STATS_EN
        chk("fwd_count", FWD_COUNT, 32'd4);
`else
        chk("fwd_count", FWD_COUNT, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
